// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the paramul matrix-multiply sequencer.
//   - state_e   : sequencer FSM states (IDLE, RUN, DRAIN, WRITE, DONE)
//   - acc_width : accumulator width derived from the element width
//   - DEF_*_BASE: default BRAM base addresses of A, B and C (row-major)
//   - READ_LAT  : BRAM read latency in cycles (address -> data)
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned READ_LAT   = 32'd1;
  localparam int unsigned DEF_A_BASE = 32'd0;
  localparam int unsigned DEF_B_BASE = 32'd16;
  localparam int unsigned DEF_C_BASE = 32'd32;

  // Full product is 2*DATA_W; four guard bits cover sums of up to 16 terms.
  function automatic int unsigned acc_width(input int unsigned data_w);
    return (32'd2 * data_w) + 32'd4;
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: handshake and BRAM-port bundle of the matmul sequencer.
//   start/busy/done          : control handshake toward the top-level FSM
//   ra_addr/ra_data          : BRAM read port A (A elements), data 1 cycle late
//   rb_addr/rb_data          : BRAM read port B (B elements), data 1 cycle late
//   w_en/w_addr/w_data       : BRAM write port (C elements)
// Modports: master = sequencer side, slave = BRAM/control side.
interface matmul_sequencer_if
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd32,
  parameter int unsigned ADDR_W = 32'd10
);

  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  modport master (
    input  start, ra_data, rb_data,
    output busy, done, ra_addr, rb_addr, w_en, w_addr, w_data
  );

  modport slave (
    output start, ra_data, rb_data,
    input  busy, done, ra_addr, rb_addr, w_en, w_addr, w_data
  );

endinterface

// File: rtl/matmul_acc.sv
// matmul_acc: signed multiply-accumulate unit of the matmul sequencer.
//   clk, reset   : clock, synchronous active-high reset (clears acc)
//   mac_vld      : a_in/b_in carry a valid operand pair this cycle
//   mac_first    : this pair is k = 0; its product loads acc directly
//   a_in, b_in   : signed DATA_W operands (BRAM read data)
//   nxt_narrow   : narrow() of the accumulator value being loaded this cycle
// Build option MATMUL_SEQ_SAT_EN: when defined narrow() saturates to the
// signed DATA_W range, otherwise it keeps the low DATA_W bits (wrap).
module matmul_acc
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_W = 32'd32,
  parameter int unsigned ACC_W  = acc_width(DATA_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mac_vld,
  input  logic                     mac_first,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic        [DATA_W-1:0] nxt_narrow
);

`ifdef MATMUL_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;

  function automatic logic [DATA_W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef MATMUL_SEQ_SAT_EN
    logic [DATA_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = DATA_W'(v);
    end
    return r;
`else
    return DATA_W'(v);
`endif
  endfunction

  // Product, accumulator next value and its narrowed form.
  always_comb begin
    prod_s     = a_in * b_in;
    prod_ext_s = ACC_W'(prod_s);
    if (mac_vld) begin
      if (mac_first) begin
        acc_d = prod_ext_s;
      end else begin
        acc_d = acc_q + prod_ext_s;
      end
    end else begin
      acc_d = acc_q;
    end
    nxt_narrow = narrow(acc_d);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= {ACC_W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: computes C = A x B for N x N signed matrices held in BRAM.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : matmul_sequencer_if.master (start/busy/done, read ports A/B,
//           write port for C)
// Each C element takes N RUN cycles (addresses issued), one DRAIN cycle (last
// product lands) and one WRITE cycle. All outputs are registered and are
// computed from the next state so they line up with the state they belong to.
// Build option MATMUL_SEQ_SAT_EN selects saturating narrowing (see matmul_acc).
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 32'd3,
  parameter int unsigned DATA_W = 32'd32,
  parameter int unsigned ADDR_W = 32'd10,
  parameter int unsigned A_BASE = DEF_A_BASE,
  parameter int unsigned B_BASE = DEF_B_BASE,
  parameter int unsigned C_BASE = DEF_C_BASE
) (
  input  logic                clk,
  input  logic                reset,
  matmul_sequencer_if.master  bus
);

  localparam int unsigned      IDX_W    = (N > 32'd1) ? $clog2(N) : 32'd1;
  localparam int unsigned      ACC_W    = acc_width(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 32'd1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    i_q, i_d;
  logic [IDX_W-1:0]    j_q, j_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [READ_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LAT-1:0] first_pipe_q, first_pipe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                w_en_q, w_en_d;
  logic [ADDR_W-1:0]   ra_addr_q, ra_addr_d;
  logic [ADDR_W-1:0]   rb_addr_q, rb_addr_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [DATA_W-1:0]   acc_narrow_s;

  // Row-major element address, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] lin_addr(input int unsigned base,
                                                  input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    int unsigned sum;
    sum = base + (32'(row) * N) + 32'(col);
    return ADDR_W'(sum);
  endfunction

  matmul_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk        (clk),
    .reset      (reset),
    .mac_vld    (vld_pipe_q[READ_LAT-1]),
    .mac_first  (first_pipe_q[READ_LAT-1]),
    .a_in       (bus.ra_data),
    .b_in       (bus.rb_data),
    .nxt_narrow (acc_narrow_s)
  );

  // Next state and index counters.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          i_d     = IDX_ZERO;
          j_d     = IDX_ZERO;
          k_d     = IDX_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_q == IDX_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DRAIN: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (j_q != IDX_LAST) begin
          j_d     = j_q + {{(IDX_W-1){1'b0}}, 1'b1};
          k_d     = IDX_ZERO;
          state_d = ST_RUN;
        end else if (i_q != IDX_LAST) begin
          i_d     = i_q + {{(IDX_W-1){1'b0}}, 1'b1};
          j_d     = IDX_ZERO;
          k_d     = IDX_ZERO;
          state_d = ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-data valid tracking: a RUN cycle's operands arrive READ_LAT cycles later.
  always_comb begin
    vld_pipe_d      = vld_pipe_q;
    first_pipe_d    = first_pipe_q;
    vld_pipe_d[0]   = (state_q == ST_RUN);
    first_pipe_d[0] = (state_q == ST_RUN) && (k_q == IDX_ZERO);
    for (int p = 1; p < READ_LAT; p++) begin
      vld_pipe_d[p]   = vld_pipe_q[p-1];
      first_pipe_d[p] = first_pipe_q[p-1];
    end
  end

  // Output next values, decoded from the state being entered.
  always_comb begin
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    w_en_d    = (state_d == ST_WRITE);
    ra_addr_d = ra_addr_q;
    rb_addr_d = rb_addr_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    if (state_d == ST_RUN) begin
      ra_addr_d = lin_addr(A_BASE, i_d, k_d);
      rb_addr_d = lin_addr(B_BASE, k_d, j_d);
    end else begin
      ra_addr_d = ra_addr_q;
      rb_addr_d = rb_addr_q;
    end
    // Entering WRITE from DRAIN: the last product is being added this cycle,
    // so the narrowed next accumulator value is the finished element.
    if (state_d == ST_WRITE) begin
      w_addr_d = lin_addr(C_BASE, i_q, j_q);
      w_data_d = acc_narrow_s;
    end else begin
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
    end
  end

  // State, index and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      i_q          <= IDX_ZERO;
      j_q          <= IDX_ZERO;
      k_q          <= IDX_ZERO;
      vld_pipe_q   <= {READ_LAT{1'b0}};
      first_pipe_q <= {READ_LAT{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_en_q       <= 1'b0;
      ra_addr_q    <= {ADDR_W{1'b0}};
      rb_addr_q    <= {ADDR_W{1'b0}};
      w_addr_q     <= {ADDR_W{1'b0}};
      w_data_q     <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      k_q          <= k_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_en_q       <= w_en_d;
      ra_addr_q    <= ra_addr_d;
      rb_addr_q    <= rb_addr_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.w_en    = w_en_q;
  assign bus.ra_addr = ra_addr_q;
  assign bus.rb_addr = rb_addr_q;
  assign bus.w_addr  = w_addr_q;
  assign bus.w_data  = w_data_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed self-checking bench for matmul_sequencer (N=3).
// A behavioural BRAM answers the read ports one cycle late; a matrix model
// computes C with plain arithmetic, and a compare process checks busy, done,
// w_en, w_addr and w_data every cycle of a run against the cycle formulas.
module tb_matmul_sequencer;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int T  = N * N * (N + 2);

  logic clk = 1'b0;
  logic reset;

  matmul_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  matmul_sequencer #(
    .N(N), .DATA_W(DW), .ADDR_W(AW), .A_BASE(0), .B_BASE(16), .C_BASE(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem  [0:1023];
  logic [31:0] cmem [0:1023];
  int          a_m  [9];
  int          b_m  [9];
  logic [31:0] expc [9];

  int errors   = 0;
  int checks   = 0;
  bit active   = 1'b0;
  int run_cyc  = 0;
  int cut      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  // BRAM read ports: registered read, data one cycle after the address.
  always @(posedge clk) begin
    bus.ra_data <= mem[bus.ra_addr];
    bus.rb_data <= mem[bus.rb_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, run_cyc, act, exp);
    end
  endtask

  // Plain matrix product, then narrowing to 32 bits.
  function automatic void build_model();
    logic signed [67:0] s, pa, pb;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 68'sd0;
        for (int k = 0; k < N; k++) begin
          pa = a_m[i*N+k];
          pb = b_m[k*N+j];
          s  = s + pa * pb;
        end
`ifdef MATMUL_SEQ_SAT_EN
        if (s > 68'sd2147483647)       expc[i*N+j] = 32'h7FFFFFFF;
        else if (s < -68'sd2147483648) expc[i*N+j] = 32'h80000000;
        else                           expc[i*N+j] = s[31:0];
`else
        expc[i*N+j] = s[31:0];
`endif
      end
    end
  endfunction

  task automatic load_mats();
    for (int x = 0; x < 1024; x++) cmem[x] = 32'h0;
    for (int x = 0; x < 9; x++) begin
      mem[x]      = a_m[x];
      mem[16 + x] = b_m[x];
    end
  endtask

  // Per-cycle compare against the schedule: writes at multiples of N+2, done at T+1.
  always @(negedge clk) begin
    bit eb, ed, ew;
    int e;
    if (active) begin
      run_cyc++;
      if (cut > 0 && run_cyc > cut) begin
        eb = 1'b0; ed = 1'b0; ew = 1'b0;
      end else begin
        eb = (run_cyc <= T + 1);
        ed = (run_cyc == T + 1);
        ew = ((run_cyc % (N + 2)) == 0) && (run_cyc <= T);
      end
      chk("busy", bus.busy, eb);
      chk("done", bus.done, ed);
      chk("w_en", bus.w_en, ew);
      if (bus.w_en) begin
        wr_cnt++;
        cmem[bus.w_addr] = bus.w_data;
      end
      if (bus.done) done_cnt++;
      if (ew && bus.w_en) begin
        e = run_cyc / (N + 2) - 1;
        chk("w_addr", bus.w_addr, 32 + e);
        chk("w_data", bus.w_data, expc[e]);
      end
      if (cut > 0 && run_cyc > cut) begin
        chk("rst_w_addr", bus.w_addr, 0);
        chk("rst_ra_addr", bus.ra_addr, 0);
      end
    end
  end

  task automatic run_mult(input int pulse_at, input int reset_at, input int exp_wr, input int exp_done);
    int last;
    cut = reset_at; wr_cnt = 0; done_cnt = 0; run_cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    active = 1'b1;
    last = (reset_at > 0) ? reset_at + 4 : T + 3;
    for (int c = 1; c <= last; c++) begin
      bus.start = (c == pulse_at);
      reset     = (c == reset_at);
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    reset  = 1'b0;
    active = 1'b0;
    chk("write_count", wr_cnt, exp_wr);
    chk("done_count", done_cnt, exp_done);
    if (reset_at == 0) begin
      for (int e = 0; e < 9; e++) chk("c_mem", cmem[32 + e], expc[e]);
    end
  endtask

  initial begin
    int t2 [9];
    t2 = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    bus.start = 1'b0;
    reset     = 1'b1;
    for (int x = 0; x < 1024; x++) mem[x] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_w_en", bus.w_en, 0);
    chk("rst_ra", bus.ra_addr, 0);
    chk("rst_rb", bus.rb_addr, 0);
    chk("rst_waddr", bus.w_addr, 0);
    chk("rst_wdata", bus.w_data, 0);
    reset = 1'b0;

    // Identity x 1024..1032.
    a_m = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    for (int x = 0; x < 9; x++) b_m[x] = 1024 + x;
    build_model();
    for (int e = 0; e < 9; e++) chk("model_ident", expc[e], 1024 + e);
    load_mats();
    run_mult(0, 0, 9, 1);
    for (int e = 0; e < 9; e++) chk("ident_lit", cmem[32 + e], 1024 + e);

    // A = B = 1..9, with an ignored start pulse at cycle 20.
    for (int x = 0; x < 9; x++) begin a_m[x] = x + 1; b_m[x] = x + 1; end
    build_model();
    for (int e = 0; e < 9; e++) chk("model_sq", expc[e], t2[e]);
    load_mats();
    run_mult(20, 0, 9, 1);

    // Overflow: row 0 of A and column 0 of B at the positive maximum.
    for (int x = 0; x < 9; x++) begin a_m[x] = 0; b_m[x] = 0; end
    a_m[0] = 32'h7FFFFFFF; a_m[1] = 32'h7FFFFFFF; a_m[2] = 32'h7FFFFFFF;
    b_m[0] = 32'h7FFFFFFF; b_m[3] = 32'h7FFFFFFF; b_m[6] = 32'h7FFFFFFF;
    build_model();
`ifdef MATMUL_SEQ_SAT_EN
    chk("model_ovf", expc[0], 32'h7FFFFFFF);
`else
    chk("model_ovf", expc[0], 32'h00000003);
`endif
    load_mats();
    run_mult(0, 0, 9, 1);

    // All -1 times all 2.
    for (int x = 0; x < 9; x++) begin a_m[x] = -1; b_m[x] = 2; end
    build_model();
    for (int e = 0; e < 9; e++) chk("model_neg", expc[e], 32'hFFFFFFFA);
    load_mats();
    run_mult(0, 0, 9, 1);

    // Reset at cycle 12, then a clean full run.
    for (int x = 0; x < 9; x++) begin a_m[x] = x + 1; b_m[x] = x + 1; end
    build_model();
    load_mats();
    run_mult(0, 12, 2, 0);
    load_mats();
    run_mult(0, 0, 9, 1);
    for (int e = 0; e < 9; e++) chk("post_rst_lit", cmem[32 + e], t2[e]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
